// File: rtl/gate_test_pkg.sv
// Shared definitions for the gate exhaustive checker: reference-function
// encodings, FSM state encoding and the behavioural reference gate.
package gate_test_pkg;

    // Reference function selectors
    localparam int unsigned OP_AND  = 0;
    localparam int unsigned OP_OR   = 1;
    localparam int unsigned OP_XOR  = 2;
    localparam int unsigned OP_NAND = 3;

    // Widest gate the reference model supports
    localparam int unsigned MaxIn = 8;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StCheck
    } state_e;

    // Expected gate output: reduction of the low n bits of vec under op.
    function automatic logic ref_gate(input int unsigned op, input logic [MaxIn-1:0] vec,
                                      input int unsigned n);
        logic r_and;
        logic r_or;
        logic r_xor;
        r_and = 1'b1;
        r_or  = 1'b0;
        r_xor = 1'b0;
        for (int unsigned i = 0; i < MaxIn; i++) begin
            if (i < n) begin
                r_and = r_and & vec[i];
                r_or  = r_or | vec[i];
                r_xor = r_xor ^ vec[i];
            end
        end
        case (op)
            OP_AND:  return r_and;
            OP_OR:   return r_or;
            OP_XOR:  return r_xor;
            OP_NAND: return ~r_and;
            default: return r_and;
        endcase
    endfunction

endpackage

// File: rtl/gate_exhaustive_checker_if.sv
// Stimulus/response bundle between the checker, its controller and the gate under test.
interface gate_exhaustive_checker_if #(
    parameter int unsigned N_IN = 2
);
    logic            start;
    logic            dut_y;
    logic [N_IN-1:0] stim;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_count;
    logic [N_IN-1:0] first_fail;

    // Controller / gate side: requests runs and returns the gate output
    modport master (
        output start, dut_y,
        input  stim, busy, done, pass, err_count, first_fail
    );

    // Checker side
    modport slave (
        input  start, dut_y,
        output stim, busy, done, pass, err_count, first_fail
    );
endinterface

// File: rtl/gate_ref_model.sv
// Combinational reference gate: expected output for the current stimulus.
module gate_ref_model
    import gate_test_pkg::*;
#(
    parameter int unsigned N_IN    = 2,
    parameter int unsigned GATE_OP = OP_AND
) (
    input  logic [N_IN-1:0] stim_i,
    output logic            exp_o
);

    // Zero-extend; ref_gate only looks at the low N_IN bits
    always_comb begin
        exp_o = ref_gate(GATE_OP, MaxIn'(stim_i), N_IN);
    end

endmodule

// File: rtl/gate_exhaustive_checker.sv
// Walks every input vector of an N_IN-input gate, holds each for SETTLE+1
// cycles, compares the sampled output with the reference and reports results.
module gate_exhaustive_checker
    import gate_test_pkg::*;
#(
    parameter int unsigned N_IN    = 2,
    parameter int unsigned SETTLE  = 2,
    parameter int unsigned GATE_OP = OP_AND
) (
    input logic                 clk,
    input logic                 rst_n,
    gate_exhaustive_checker_if.slave bus_io
);

    localparam int unsigned ErrW = N_IN + 1;
    localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    if (SETTLE < 1) begin : g_bad_settle
        $error("gate_exhaustive_checker: SETTLE must be at least 1");
    end
    if (N_IN < 1 || N_IN > MaxIn) begin : g_bad_n_in
        $error("gate_exhaustive_checker: N_IN must be in 1..8");
    end
    if (GATE_OP > OP_NAND) begin : g_bad_op
        $error("gate_exhaustive_checker: unknown GATE_OP");
    end

    state_e          state_q, state_d;
    logic [N_IN-1:0] stim_q, stim_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [ErrW-1:0] err_q, err_d;
    logic [N_IN-1:0] ff_q, ff_d;
    logic            seen_q, seen_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic            expected;
    logic            mismatch;

    gate_ref_model #(
        .N_IN   (N_IN),
        .GATE_OP(GATE_OP)
    ) u_ref (
        .stim_i(stim_q),
        .exp_o (expected)
    );

    // Case inequality so an X/Z from the gate counts as a failure in simulation
    assign mismatch = (bus_io.dut_y !== expected);

    // Next-state and registered-output decisions for the stimulus FSM
    always_comb begin
        state_d = state_q;
        stim_d  = stim_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        ff_d    = ff_q;
        seen_d  = seen_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        unique case (state_q)
            StIdle: begin
                if (bus_io.start) begin
                    stim_d  = '0;
                    err_d   = '0;
                    ff_d    = '0;
                    seen_d  = 1'b0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = StSettle;
                end
            end
            StSettle: begin
                if (cnt_q == CntW'(SETTLE - 1)) begin
                    state_d = StCheck;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StCheck: begin
                err_d = err_q + ErrW'(mismatch);
                if (mismatch && !seen_q) begin
                    ff_d   = stim_q;
                    seen_d = 1'b1;
                end
                if (!(&stim_q)) begin
                    stim_d  = stim_q + 1'b1;
                    cnt_d   = '0;
                    state_d = StSettle;
                end else begin
                    // Last vector: verdict includes this compare
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and result registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            stim_q  <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            ff_q    <= '0;
            seen_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stim_q  <= stim_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            seen_q  <= seen_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign bus_io.stim       = stim_q;
    assign bus_io.busy       = busy_q;
    assign bus_io.done       = done_q;
    assign bus_io.pass       = pass_q;
    assign bus_io.err_count  = err_q;
    assign bus_io.first_fail = ff_q;

endmodule

// File: tb/tb_gate_exhaustive_checker.sv
// Directed bench: 2-input AND checker (golden, stuck-at-1, stuck-at-0, held
// start, async reset mid-run) and 3-input XOR checker (golden, inverted).
module tb_gate_exhaustive_checker;

    logic clk;
    logic rst_n;
    int   mode0;   // 0: good AND, 1: stuck-at-1, 2: stuck-at-0
    logic inv1;    // invert the 3-input XOR gate
    int   n_vec;
    int   n_err;

    gate_exhaustive_checker_if #(.N_IN(2)) bus0 ();
    gate_exhaustive_checker_if #(.N_IN(3)) bus1 ();

    gate_exhaustive_checker #(
        .N_IN   (2),
        .SETTLE (2),
        .GATE_OP(0)
    ) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus_io(bus0)
    );

    gate_exhaustive_checker #(
        .N_IN   (3),
        .SETTLE (1),
        .GATE_OP(2)
    ) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus_io(bus1)
    );

    // Gates under test
    assign bus0.dut_y = (mode0 == 0) ? (bus0.stim[0] & bus0.stim[1]) : (mode0 == 1);
    assign bus1.dut_y = bus1.stim[0] ^ bus1.stim[1] ^ bus1.stim[2] ^ inv1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start request sampled by exactly one rising edge
    task automatic pulse0();
        @(negedge clk);
        bus0.start = 1'b1;
        @(posedge clk);
        #1 bus0.start = 1'b0;
    endtask

    task automatic pulse1();
        @(negedge clk);
        bus1.start = 1'b1;
        @(posedge clk);
        #1 bus1.start = 1'b0;
    endtask

    // Edges after the start edge until done rises; -1 if it never does.
    // Optionally checks that each 2-bit vector is held for 3 cycles.
    task automatic wait_done0(output int lat, input bit track);
        int e;
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (track) begin
                e = (i / 3 > 3) ? 3 : i / 3;
                chk("stim_hold", 32'(bus0.stim), 32'(e));
            end
            if (bus0.done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic wait_done1(output int lat);
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (bus1.done) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        n_vec      = 0;
        n_err      = 0;
        mode0      = 0;
        inv1       = 1'b0;
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        rst_n      = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_stim", 32'(bus0.stim), 0);
        chk("rst_busy", 32'(bus0.busy), 0);
        chk("rst_done", 32'(bus0.done), 0);
        chk("rst_pass", 32'(bus0.pass), 0);
        chk("rst_err", 32'(bus0.err_count), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Golden AND: done on the 12th edge after the start edge (13th counting it)
        pulse0();
        chk("and_busy_run", 32'(bus0.busy), 1);
        wait_done0(lat, 1'b1);
        chk("and_latency", 32'(lat), 12);
        chk("and_pass", 32'(bus0.pass), 1);
        chk("and_err", 32'(bus0.err_count), 0);
        chk("and_ff", 32'(bus0.first_fail), 0);
        chk("and_busy", 32'(bus0.busy), 0);

        // Results hold while idle
        repeat (3) @(posedge clk);
        #1;
        chk("hold_done", 32'(bus0.done), 1);
        chk("hold_pass", 32'(bus0.pass), 1);
        chk("hold_stim", 32'(bus0.stim), 3);

        // Stuck-at-1: vectors 00,01,10 fail
        mode0 = 1;
        pulse0();
        chk("s1_done_clr", 32'(bus0.done), 0);
        wait_done0(lat, 1'b0);
        chk("s1_latency", 32'(lat), 12);
        chk("s1_err", 32'(bus0.err_count), 3);
        chk("s1_ff", 32'(bus0.first_fail), 0);
        chk("s1_pass", 32'(bus0.pass), 0);

        // Stuck-at-0: only 11 fails
        mode0 = 2;
        pulse0();
        wait_done0(lat, 1'b0);
        chk("s0_err", 32'(bus0.err_count), 1);
        chk("s0_ff", 32'(bus0.first_fail), 3);
        chk("s0_pass", 32'(bus0.pass), 0);

        // Held start with stuck-at-1 gate: restart on the edge after done
        mode0 = 1;
        @(negedge clk);
        bus0.start = 1'b1;
        @(posedge clk);
        wait_done0(lat, 1'b0);
        chk("held_latency", 32'(lat), 12);
        chk("held_err1", 32'(bus0.err_count), 3);
        chk("held_busy_gap", 32'(bus0.busy), 0);
        @(posedge clk);
        #1;
        chk("held_restart_done", 32'(bus0.done), 0);
        chk("held_restart_busy", 32'(bus0.busy), 1);
        chk("held_restart_err", 32'(bus0.err_count), 0);
        chk("held_restart_stim", 32'(bus0.stim), 0);

        // Async reset mid-run (cycle 6 of the restarted run)
        repeat (5) @(posedge clk);
        #1;
        chk("mid_stim", 32'(bus0.stim), 1);
        chk("mid_err", 32'(bus0.err_count), 1);
        bus0.start = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("arst_stim", 32'(bus0.stim), 0);
        chk("arst_busy", 32'(bus0.busy), 0);
        chk("arst_err", 32'(bus0.err_count), 0);
        chk("arst_ff", 32'(bus0.first_fail), 0);
        chk("arst_done", 32'(bus0.done), 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("post_rst_stim", 32'(bus0.stim), 0);
        chk("post_rst_busy", 32'(bus0.busy), 0);

        // 3-input XOR, SETTLE=1: 8 vectors x 2 cycles
        pulse1();
        wait_done1(lat);
        chk("xor_latency", 32'(lat), 16);
        chk("xor_pass", 32'(bus1.pass), 1);
        chk("xor_err", 32'(bus1.err_count), 0);
        chk("xor_stim_end", 32'(bus1.stim), 7);

        inv1 = 1'b1;
        pulse1();
        wait_done1(lat);
        chk("xinv_err", 32'(bus1.err_count), 8);
        chk("xinv_ff", 32'(bus1.first_fail), 0);
        chk("xinv_pass", 32'(bus1.pass), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
